// File: rtl/cr_kme_fifo_arb.sv
// Round-robin packet arbiter in front of a cr_kme_fifo write port.
// Whole packets are forwarded without interleaving. Each packet costs
// one IDLE arbitration cycle, then moves one beat per cycle.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_valid_i/eop_i   per-requester beat valid and last-beat flag
//   req_data_i          requester i at [i*DATA_SIZE +: DATA_SIZE]
//   req_stall_o         per-requester stall (combinational)
//   fifo_in_*_o         beat, valid, eop and source id to the FIFO (combinational)
//   fifo_in_stall_i     FIFO full indication
//   busy_o              high while a packet owns the port
//   pkt_cnt_o           count of completed packets, wraps at 16 bits
module cr_kme_fifo_arb #(
    parameter int unsigned DATA_SIZE = 256,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned SRC_W     = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]           req_eop_i,
    output logic [NUM_REQ-1:0]           req_stall_o,
    output logic [DATA_SIZE-1:0]         fifo_in_o,
    output logic                         fifo_in_valid_o,
    output logic                         fifo_in_eop_o,
    output logic [SRC_W-1:0]             fifo_in_src_o,
    input  logic                         fifo_in_stall_i,
    output logic                         busy_o,
    output logic [15:0]                  pkt_cnt_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [SRC_W-1:0] owner_q, owner_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [15:0]      pkt_cnt_q, pkt_cnt_d;

    logic [SRC_W-1:0] pick;
    logic [SRC_W-1:0] owner_next;
    logic             lock;
    logic             owner_eop;

    // Lock is masked by reset so the port drops in the first reset cycle.
    assign lock      = (state_q == ST_LOCK) && !rst_i;
    assign owner_eop = req_eop_i[owner_q];

    // Owner datapath: zero-latency mux from the locked requester.
    assign fifo_in_valid_o = lock && req_valid_i[owner_q] && !fifo_in_stall_i;
    assign fifo_in_o       = req_data_i[owner_q*DATA_SIZE +: DATA_SIZE];
    assign fifo_in_eop_o   = owner_eop;
    assign fifo_in_src_o   = owner_q;

    assign busy_o    = (state_q == ST_LOCK);
    assign pkt_cnt_o = pkt_cnt_q;

    // Only the owner may move, and only while the FIFO accepts.
    always_comb begin
        req_stall_o = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_stall_o[i] = !(lock && (owner_q == SRC_W'(i)) && !fifo_in_stall_i);
        end
    end

    // First valid requester searching upward from rr_ptr, wrapping.
    always_comb begin
        logic        found;
        int unsigned idx;
        pick  = rr_ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && req_valid_i[SRC_W'(idx)]) begin
                pick  = SRC_W'(idx);
                found = 1'b1;
            end
        end
    end

    // Pointer to the requester after the current owner (mod NUM_REQ).
    assign owner_next = (owner_q == SRC_W'(NUM_REQ - 1)) ? '0 : owner_q + SRC_W'(1);

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid_i) begin
                    owner_d = pick;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (fifo_in_valid_o && owner_eop) begin
                    state_d   = ST_IDLE;
                    rr_ptr_d  = owner_next;
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

endmodule

// File: tb/tb_cr_kme_fifo_arb.sv
// Directed bench for cr_kme_fifo_arb: requester models feed packets, a
// scoreboard queue holds the hand-ordered expected FIFO beats and a
// separate monitor checks every beat the arbiter writes.
module tb_cr_kme_fifo_arb;

    localparam int unsigned DW = 256;
    localparam int unsigned NR = 4;
    localparam int unsigned SW = 2;
    localparam int unsigned DEPTH = 32;

    logic               clk;
    logic               rst;
    logic [NR-1:0]      req_valid;
    logic [NR*DW-1:0]   req_data;
    logic [NR-1:0]      req_eop;
    logic [NR-1:0]      req_stall;
    logic [DW-1:0]      fifo_in;
    logic               fifo_in_valid;
    logic               fifo_in_eop;
    logic [SW-1:0]      fifo_in_src;
    logic               fifo_in_stall;
    logic               busy;
    logic [15:0]        pkt_cnt;

    cr_kme_fifo_arb #(.DATA_SIZE(DW), .NUM_REQ(NR), .SRC_W(SW)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_data_i      (req_data),
        .req_eop_i       (req_eop),
        .req_stall_o     (req_stall),
        .fifo_in_o       (fifo_in),
        .fifo_in_valid_o (fifo_in_valid),
        .fifo_in_eop_o   (fifo_in_eop),
        .fifo_in_src_o   (fifo_in_src),
        .fifo_in_stall_i (fifo_in_stall),
        .busy_o          (busy),
        .pkt_cnt_o       (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          eop;
        logic [SW-1:0] src;
    } exp_t;

    exp_t          exp_q[$];
    int            checks   = 0;
    int            failures = 0;
    int            beats_seen = 0;

    // Requester models: a small beat store per requester.
    logic [DW-1:0] rdat [NR][DEPTH];
    logic          reop [NR][DEPTH];
    int            rhead [NR];
    int            rtail [NR];
    logic [NR-1:0] gate;
    logic [NR-1:0] xfer;

    function automatic logic [DW-1:0] mk(input int s, input int n);
        logic [31:0] w;
        w  = {8'(s), 8'(n), 16'hC3A5};
        mk = {8{w}} ^ DW'(n * 40503 + s);
    endfunction

    function automatic logic pending();
        pending = 1'b0;
        for (int i = 0; i < NR; i++) if (rhead[i] != rtail[i]) pending = 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic update_drive();
        for (int i = 0; i < NR; i++) begin
            if (rhead[i] != rtail[i] && !gate[i]) begin
                req_valid[i]           = 1'b1;
                req_data[i*DW +: DW]   = rdat[i][rhead[i]];
                req_eop[i]             = reop[i][rhead[i]];
            end else begin
                req_valid[i]           = 1'b0;
                req_data[i*DW +: DW]   = '0;
                req_eop[i]             = 1'b0;
            end
        end
    endtask

    task automatic add_pkt(input int s, input int n, input int tag);
        if (rhead[s] == rtail[s]) begin
            rhead[s] = 0;
            rtail[s] = 0;
        end
        for (int b = 0; b < n; b++) begin
            rdat[s][rtail[s]] = mk(s, tag * 16 + b);
            reop[s][rtail[s]] = (b == n - 1);
            rtail[s]++;
        end
        update_drive();
    endtask

    // Expected beats are pushed in hand-computed grant order.
    task automatic expect_pkt(input int s, input int n, input int nsent, input int tag);
        exp_t e;
        for (int b = 0; b < nsent; b++) begin
            e.d   = mk(s, tag * 16 + b);
            e.eop = (b == n - 1);
            e.src = SW'(s);
            exp_q.push_back(e);
        end
    endtask

    // Transfer sampling mid-cycle, away from the clock edge.
    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) xfer[i] <= req_valid[i] && !req_stall[i];
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (xfer[i] && rhead[i] != rtail[i]) rhead[i]++;
        end
        update_drive();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((pending() || exp_q.size() != 0) && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL drain_timeout act=%0d pending beats exp=0", exp_q.size());
        end
    endtask

    // Monitor: every FIFO write is popped against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (fifo_in_stall) begin
                checks++;
                if (fifo_in_valid) begin
                    failures++;
                    $display("FAIL overflow act=fifo_in_valid=1 exp=0 while stalled");
                end
            end
            if (fifo_in_valid) begin
                beats_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected act=src%0d exp=no beat", fifo_in_src);
                end else begin
                    e = exp_q.pop_front();
                    if (fifo_in !== e.d || fifo_in_eop !== e.eop || fifo_in_src !== e.src) begin
                        failures++;
                        $display("FAIL sb_beat act=src%0d eop%0b %h exp=src%0d eop%0b %h",
                                 fifo_in_src, fifo_in_eop, fifo_in, e.src, e.eop, e.d);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        rst           = 1'b1;
        fifo_in_stall = 1'b0;
        gate          = '0;
        xfer          = '0;
        for (int i = 0; i < NR; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end
        update_drive();

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(pkt_cnt), 32'd0);
        chk("rst_valid", 32'(fifo_in_valid), 32'd0);
        chk("rst_stall", 32'(req_stall), 32'hF);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fairness: everyone offers two 1-beat packets; grants 0,1,2,3,0,1,2,3.
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < NR; s++) begin
                add_pkt(s, 1, r);
                expect_pkt(s, 1, 1, r);
            end
        end
        b0 = beats_seen;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("rr_beat_cadence", 32'(fifo_in_valid), 32'(k % 2));
            step();
        end
        @(negedge clk);
        chk("rr_pkt_cnt", 32'(pkt_cnt), 32'd8);
        chk("rr_beats", 32'(beats_seen - b0), 32'd8);
        step();

        // Single requester 1, 3 beats; rr_ptr is 0 here.
        add_pkt(1, 3, 2);
        expect_pkt(1, 3, 3, 2);
        @(negedge clk);
        chk("single_idle_valid", 32'(fifo_in_valid), 32'd0);
        chk("single_idle_busy", 32'(busy), 32'd0);
        chk("single_idle_stall", 32'(req_stall), 32'hF);
        step();
        @(negedge clk);
        chk("single_lock_busy", 32'(busy), 32'd1);
        chk("single_lock_stall", 32'(req_stall), 32'hD);
        step();
        drain();
        @(negedge clk);
        chk("single_pkt_cnt", 32'(pkt_cnt), 32'd9);
        chk("single_busy_end", 32'(busy), 32'd0);
        step();

        // rr_ptr is 2 after requester 1: with 0,2,3 valid the order is 2,3,0.
        add_pkt(0, 1, 3);
        add_pkt(2, 1, 3);
        add_pkt(3, 1, 3);
        expect_pkt(2, 1, 1, 3);
        expect_pkt(3, 1, 1, 3);
        expect_pkt(0, 1, 1, 3);
        drain();
        @(negedge clk);
        chk("rrptr_pkt_cnt", 32'(pkt_cnt), 32'd12);
        step();

        // No interleave: requester 2 arrives during requester 0's packet.
        gate[2] = 1'b1;
        add_pkt(0, 4, 4);
        add_pkt(2, 1, 4);
        expect_pkt(0, 4, 4, 4);
        expect_pkt(2, 1, 1, 4);
        @(negedge clk);
        step();
        @(negedge clk);
        step();
        gate[2] = 1'b0;
        update_drive();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("nointl_stall2", 32'(req_stall[2]), 32'd1);
            chk("nointl_src", 32'(fifo_in_src), 32'd0);
            step();
        end
        drain();
        @(negedge clk);
        chk("nointl_pkt_cnt", 32'(pkt_cnt), 32'd14);
        step();

        // FIFO stall for 3 cycles mid-packet; rr_ptr 3 so requester 1 wins.
        add_pkt(1, 4, 5);
        expect_pkt(1, 4, 4, 5);
        @(negedge clk);
        step();
        @(negedge clk);
        step();
        fifo_in_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_valid", 32'(fifo_in_valid), 32'd0);
            chk("stall_owner", 32'(req_stall[1]), 32'd1);
            step();
        end
        fifo_in_stall = 1'b0;
        drain();
        @(negedge clk);
        chk("stall_pkt_cnt", 32'(pkt_cnt), 32'd15);
        step();

        // Reset mid-packet: requester 0 (rr_ptr 2) sends 2 of 4 beats.
        add_pkt(0, 4, 6);
        expect_pkt(0, 4, 2, 6);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            step();
        end
        rst = 1'b1;
        rhead[0] = rtail[0];
        update_drive();
        @(negedge clk);
        chk("mrst_valid", 32'(fifo_in_valid), 32'd0);
        chk("mrst_stall", 32'(req_stall), 32'hF);
        step();
        @(negedge clk);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_cnt", 32'(pkt_cnt), 32'd0);
        chk("mrst_stall2", 32'(req_stall), 32'hF);
        chk("mrst_sb_empty", 32'(exp_q.size()), 32'd0);
        step();
        rst = 1'b0;
        // Search restarts at 0: requester 1 before requester 3.
        add_pkt(1, 1, 7);
        add_pkt(3, 2, 7);
        expect_pkt(1, 1, 1, 7);
        expect_pkt(3, 2, 2, 7);
        @(negedge clk);
        chk("mrst_idle_valid", 32'(fifo_in_valid), 32'd0);
        step();
        @(negedge clk);
        chk("mrst_grant_src", 32'(fifo_in_src), 32'd1);
        chk("mrst_grant_valid", 32'(fifo_in_valid), 32'd1);
        step();
        drain();
        @(negedge clk);
        chk("mrst_pkt_cnt", 32'(pkt_cnt), 32'd2);
        step();

        // Counter wrap: preload 0xFFFE, then two packets.
        force dut.pkt_cnt_q = 16'hFFFE;
        step();
        release dut.pkt_cnt_q;
        add_pkt(2, 1, 8);
        expect_pkt(2, 1, 1, 8);
        drain();
        @(negedge clk);
        chk("wrap_ffff", 32'(pkt_cnt), 32'hFFFF);
        step();
        add_pkt(2, 2, 9);
        expect_pkt(2, 2, 2, 9);
        drain();
        @(negedge clk);
        chk("wrap_zero", 32'(pkt_cnt), 32'h0000);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
